// File: rtl/address_unit.sv
// Address generation for the CPU core: reset-vector fetch, program counter
// and the external address-bus mux with a held-address register.
module address_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        pc_enable,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  data_in,
  output logic [15:0] address_out,
  output logic [15:0] pc_out,
  output logic        vector_busy
);

  // state    | meaning
  // S_VEC_LO | fetching reset-vector low byte
  // S_VEC_HI | fetching reset-vector high byte
  // S_RUN    | normal operation, address from address_select
  typedef enum logic [1:0] {
    S_VEC_LO = 2'd0,
    S_VEC_HI = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_VEC_LO;
      pc        <= 16'h0000;
      last_addr <= 16'h0000;
    end else if (rdy) begin
      state     <= state_next;
      pc        <= pc_next;
      last_addr <= address_out;
    end
  end

  always_comb begin
    state_next  = S_VEC_LO;
    pc_next     = pc;
    address_out = RESET_VECTOR;
    vector_busy = 1'b1;
    unique case (state)
      S_VEC_LO: begin
        address_out = RESET_VECTOR;
        pc_next     = {pc[15:8], data_in};
        state_next  = S_VEC_HI;
      end
      S_VEC_HI: begin
        address_out = VEC_HI_ADDR;
        pc_next     = {data_in, pc[7:0]};
        state_next  = S_RUN;
      end
      S_RUN: begin
        vector_busy = 1'b0;
        state_next  = S_RUN;
        case (address_select)
          2'd0:    address_out = pc;
          2'd1:    address_out = memory_address;
          2'd2:    address_out = {8'h00, alu_result};
          default: address_out = last_addr;
        endcase
        // load wins over increment; increment wraps naturally at 16 bits
        if (pc_load)
          pc_next = pc_load_value;
        else if (pc_enable)
          pc_next = pc + 16'd1;
      end
      default: begin
        state_next  = S_VEC_LO;
      end
    endcase
  end

  assign pc_out = pc;

endmodule
